pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register for the MIPS pipeline (IF/ID and later stage boundaries).
//  Carries {instr, pc} with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.
//  Emits NOP_INSTR as a bubble whenever empty, so the downstream decode never sees stale data.
//  Latency 1 cycle; sustains 1 beat/cycle; in_ready comes straight from a flop.
// PARAMETERS
//  INSTR_W    16       instruction payload width
//  PC_W       16       pc (pc+2) payload width
//  NOP_INSTR  16'h0000 instruction presented on out_instr when out_valid=0
//  CNT_W      16       perf counter width (PIPE_REG_PERF_EN only)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        upstream beat valid
//  in_ready   out  1        stage can accept a beat; registered
//  in_instr   in   INSTR_W  upstream instruction
//  in_pc      in   PC_W     upstream pc+2
//  flush      in   1        discard all held beats and the same-cycle input beat
//  out_valid  out  1        beat presented downstream
//  out_ready  in   1        downstream accepts
//  out_instr  out  INSTR_W  held instruction, or NOP_INSTR when !out_valid
//  out_pc     out  PC_W     held pc+2, or 0 when !out_valid
//  stall_cnt  out  CNT_W    cycles with out_valid & !out_ready
//  bubble_cnt out  CNT_W    cycles with !out_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=EMPTY, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0, counters=0.
//  Accept = in_valid & in_ready. Release = out_valid & out_ready.
//  Storage: main register (drives out_*) and skid register.
//  States:
//   EMPTY: out_valid=0, in_ready=1.
//    Accept -> load main, go to ONE.
//   ONE: out_valid=1, in_ready=1.
//    Accept & Release -> main<=input, stay in ONE.
//    Accept & !Release -> skid<=input, go to TWO.
//    !Accept & Release -> go to EMPTY.
//    Neither -> hold.
//   TWO: out_valid=1, in_ready=0; in_valid is ignored.
//    Release -> main<=skid, go to ONE.
//    No release -> hold.
//  flush has priority over every transition: next state=EMPTY.
//   The same-cycle input beat is dropped.
//   The same-cycle release still counts as consumed downstream.
//   Next cycle: out_valid=0, out_instr=NOP_INSTR, in_ready=1.
//  Ordering: beats leave in arrival order; none are lost or duplicated except by flush.
//  in_ready=(state!=TWO), decoded from the state flop only. No combinational path from out_ready to in_ready.
//  rst_n asserted mid-transfer: held beats are discarded immediately; no partial beat is ever presented.
//  Payload is held stable while out_valid & !out_ready.
// CONFIGURATION
//  `PIPE_REG_PERF_EN defined:
//   stall_cnt and bubble_cnt each increment once per qualifying cycle.
//   Both saturate at all-ones; they are cleared only by reset, not by flush.
//  `PIPE_REG_PERF_EN undefined: ports are still present, tied to 0; no counter flops are synthesised.
// STRUCTURE
//  Package mips_pipe_pkg holds INSTR_W/PC_W defaults, NOP_INSTR, and typedef enum {EMPTY,ONE,TWO} pipe_state_t.
//  Sub-module pipe_sat_ctr (CNT_W saturating counter with inc input) is instantiated twice, only under the macro.
// TESTING
//  1 Reset, then idle: out_valid=0, out_instr=0x0000, in_ready=1, bubble_cnt climbs 1 per cycle.
//  2 Stream 0x1111/0x2222/0x3333 (pc 2/4/6) with out_ready=1:
//     each appears 1 cycle after its accept, back to back, and stall_cnt stays 0.
//  3 out_ready=0 while pushing 0x1111, 0x2222, 0x3333:
//     first two are held, in_ready falls after the second, and 0x3333 waits.
//     Raising out_ready yields 1111, 2222, 3333 in order.
//  4 flush in state TWO with in_valid=1 (0x4444):
//     next cycle out_valid=0, out_instr=NOP, and 0x4444 never appears.
//  5 rst_n pulsed low asynchronously mid-cycle with 2 beats held:
//     outputs go to reset values before the next edge, and counters read 0.
//  6 Stall 5 cycles with a beat held and the macro on: stall_cnt=5.
//     With CNT_W=2, the same run gives stall_cnt=3 (saturated). Macro off: both counters read 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared widths, bubble encoding and state type for the pipeline registers
package mips_pipe_pkg;

  localparam int          INSTR_W_DEF   = 16;
  localparam int          PC_W_DEF      = 16;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_sat_ctr.sv
// rtl/pipe_sat_ctr.sv - saturating event counter, cleared only by reset
module pipe_sat_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic {instr,pc} stage register with 2-entry skid and flush
// Perf counters are built only when PIPE_REG_PERF_EN is defined; otherwise they read 0.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 PC_W      = PC_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  pipe_state_t        state;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic               accept, release_beat;

  // Handshake flags come only from the state flop, so out_ready never reaches in_ready.
  assign in_ready     = (state != TWO);
  assign out_valid    = (state != EMPTY);
  assign accept       = in_valid & in_ready;
  assign release_beat = out_valid & out_ready;

  assign out_instr = out_valid ? main_instr : NOP_INSTR;
  assign out_pc    = out_valid ? main_pc    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_instr <= '0;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && release_beat) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
          end else if (accept) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            state      <= TWO;
          end else if (release_beat) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (release_beat) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            state      <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_REG_PERF_EN
  pipe_sat_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_ctr #(.CNT_W(CNT_W)) u_bubble_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid),
    .cnt   (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed scoreboard bench for pipe_stage_reg
// Counter expectations follow PIPE_REG_PERF_EN; a CNT_W=2 copy shows saturation.
module tb_pipe_stage_reg;

`ifdef PIPE_REG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_instr, in_pc, out_instr, out_pc, stall_cnt, bubble_cnt;
  logic        in_ready2, out_valid2;
  logic [15:0] out_instr2, out_pc2;
  logic [1:0]  stall_cnt2, bubble_cnt2;

  logic [31:0] sb[$];
  int          total = 0;
  int          bad = 0;
  int          exp_stall, exp_bubble, exp_stall2, exp_bubble2;
  bit          held;
  logic [31:0] held_beat;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
    .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Called at a falling edge: check outputs, book the handshake, advance one cycle.
  task automatic tick();
    logic [31:0] exp_beat;
    chk("stall_cnt", {16'h0, stall_cnt}, PERF ? exp_stall : 0);
    chk("bubble_cnt", {16'h0, bubble_cnt}, PERF ? exp_bubble : 0);
    chk("stall_cnt_w2", {30'h0, stall_cnt2}, PERF ? exp_stall2 : 0);
    chk("bubble_cnt_w2", {30'h0, bubble_cnt2}, PERF ? exp_bubble2 : 0);
    if (!out_valid) begin
      chk("bubble_payload", {out_instr, out_pc}, 32'h0);
    end else if (held) begin
      chk("stall_stable", {out_instr, out_pc}, held_beat);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_beat", {31'h0, out_valid}, 32'h0);
      end else begin
        exp_beat = sb.pop_front();
        chk("sb_beat", {out_instr, out_pc}, exp_beat);
      end
    end
    held      = out_valid && !out_ready && !flush;
    held_beat = {out_instr, out_pc};
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back({in_instr, in_pc});
    if (out_valid && !out_ready) begin
      exp_stall  = (exp_stall < 65535) ? exp_stall + 1 : 65535;
      exp_stall2 = (exp_stall2 < 3) ? exp_stall2 + 1 : 3;
    end
    if (!out_valid) begin
      exp_bubble  = (exp_bubble < 65535) ? exp_bubble + 1 : 65535;
      exp_bubble2 = (exp_bubble2 < 3) ? exp_bubble2 + 1 : 3;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    chk({tag, "_payload"}, {out_instr, out_pc}, 32'h0);
    chk({tag, "_cnts"}, {stall_cnt, bubble_cnt}, 32'h0);
  endtask

  // Async reset pulse inside the low clock phase; the following edge is one bubble cycle.
  task automatic pulse_reset(input bit check);
    #2 rst_n = 1'b0;
    #1;
    if (check) check_reset_outputs("async_rst");
    sb.delete();
    held = 1'b0;
    #1 rst_n = 1'b1;
    exp_stall   = 0;
    exp_stall2  = 0;
    exp_bubble  = 1;
    exp_bubble2 = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    held  = 1'b0;
    exp_stall = 0; exp_bubble = 0; exp_stall2 = 0; exp_bubble2 = 0;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    repeat (3) tick();
    chk("idle_bubble_cnt", {16'h0, bubble_cnt}, PERF ? 3 : 0);

    // streaming with out_ready high
    drive(1'b1, 16'h1111, 16'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h2222, 16'd4, 1'b1, 1'b0);
    chk("stream_1111", {out_instr, out_pc}, {16'h1111, 16'd2});
    tick();
    drive(1'b1, 16'h3333, 16'd6, 1'b1, 1'b0);
    chk("stream_2222", {out_instr, out_pc}, {16'h2222, 16'd4});
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("stream_3333", {out_instr, out_pc}, {16'h3333, 16'd6});
    tick();
    chk("stream_empty", {31'h0, out_valid}, 32'h0);
    chk("stream_no_stall", {16'h0, stall_cnt}, 32'h0);

    // backpressure fills main and skid
    drive(1'b1, 16'h1111, 16'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h2222, 16'd4, 1'b0, 1'b0);
    chk("bp_ready_one", {31'h0, in_ready}, 32'h1);
    tick();
    drive(1'b1, 16'h3333, 16'd6, 1'b0, 1'b0);
    chk("bp_ready_two", {31'h0, in_ready}, 32'h0);
    tick();
    tick();
    chk("bp_still_full", {31'h0, in_ready}, 32'h0);
    chk("bp_head", {out_instr, out_pc}, {16'h1111, 16'd2});
    drive(1'b1, 16'h3333, 16'd6, 1'b1, 1'b0); tick();
    chk("bp_ready_back", {31'h0, in_ready}, 32'h1);
    chk("bp_second", {out_instr, out_pc}, {16'h2222, 16'd4});
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("bp_third", {out_instr, out_pc}, {16'h3333, 16'd6});
    tick();
    tick();
    chk("bp_drained", sb.size(), 0);

    // flush while full, with a beat offered in the same cycle
    drive(1'b1, 16'h5555, 16'd8, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h6666, 16'd10, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h4444, 16'd12, 1'b0, 1'b1); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("flush_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_nop", {16'h0, out_instr}, 32'h0);
    chk("flush_ready", {31'h0, in_ready}, 32'h1);
    repeat (3) tick();

    // async reset with two beats held
    drive(1'b1, 16'h7777, 16'd14, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h8888, 16'd16, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("pre_rst_full", {31'h0, in_ready}, 32'h0);
    pulse_reset(1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    repeat (2) tick();

    // stall counting and saturation
    pulse_reset(1'b0);
    drive(1'b1, 16'h9999, 16'd18, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("stall5", {16'h0, stall_cnt}, PERF ? 5 : 0);
    chk("stall5_sat_w2", {30'h0, stall_cnt2}, PERF ? 3 : 0);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); tick();
    tick();
    chk("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
